// File: rtl/btb_pkg.sv
// Shared types, constants and counter helpers for the set-associative BTB.
// The typedefs describe the default configuration; the top rebuilds them from its own parameters.
package btb_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_NUM_SETS = 8;
    localparam int unsigned DEF_NUM_WAYS = 2;
    localparam int unsigned DEF_CTR_W    = 2;
    localparam int unsigned DEF_TAG_W    = DEF_ADDR_W - clog2(DEF_NUM_SETS) - 2;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_ADDR_W-1:0] target;
        logic [DEF_CTR_W-1:0]  ctr;
    } btb_entry_t;

    typedef btb_entry_t [DEF_NUM_WAYS-1:0] btb_set_t;

    localparam logic [DEF_CTR_W-1:0] CTR_WEAK_TAKEN = 2'b10;

    function automatic logic [31:0] ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and execute-side update bundle of the BTB.
interface btb_assoc_if #(parameter int unsigned ADDR_W = 32);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target_pc;
    logic              valid;
    logic              predicted_taken;
    logic              update;
    logic [ADDR_W-1:0] update_pc;
    logic [ADDR_W-1:0] update_target;
    logic              update_taken;
    logic              flush;

    modport master (
        output pc, update, update_pc, update_target, update_taken, flush,
        input  target_pc, valid, predicted_taken
    );

    modport slave (
        input  pc, update, update_pc, update_target, update_taken, flush,
        output target_pc, valid, predicted_taken
    );
endinterface

// File: rtl/btb_victim_sel.sv
// Hit priority encoder (lowest matching way wins) and victim choice:
// lowest invalid way, otherwise the set's round-robin pointer.
module btb_victim_sel #(
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned WAY_W    = 1
) (
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] match,
    input  logic [WAY_W-1:0]    ptr,
    output logic                hit,
    output logic [WAY_W-1:0]    hit_way,
    output logic [WAY_W-1:0]    victim_way
);
    logic any_invalid_s;
    logic [WAY_W-1:0] first_invalid_s;

    // Scan from the top down so the lowest qualifying way is the last one kept.
    always_comb begin
        hit             = 1'b0;
        hit_way         = '0;
        any_invalid_s   = 1'b0;
        first_invalid_s = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit             = hit | (valid[w] & match[w]);
            hit_way         = (valid[w] & match[w]) ? WAY_W'(w) : hit_way;
            any_invalid_s   = any_invalid_s | ~valid[w];
            first_invalid_s = (~valid[w]) ? WAY_W'(w) : first_invalid_s;
        end
        victim_way = any_invalid_s ? first_invalid_s : ptr;
    end
endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup, two-stage update
// (compute into a pending register, commit next cycle) with bypass of the pending set.
module btb_assoc import btb_pkg::*; #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned CTR_W    = 2
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);
    localparam int unsigned IDX_W = clog2(NUM_SETS);
    localparam int unsigned WAY_W = (clog2(NUM_WAYS) > 0) ? clog2(NUM_WAYS) : 1;
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(ctr_weak_taken(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;
    typedef entry_t [NUM_WAYS-1:0] set_t;

    set_t             sets_r [NUM_SETS];
    logic [WAY_W-1:0] ptr_r  [NUM_SETS];
    logic             pend_valid_r;
    logic [IDX_W-1:0] pend_idx_r;
    set_t             pend_set_r;
    logic [WAY_W-1:0] pend_ptr_r;

    logic [IDX_W-1:0]    l_idx_s, u_idx_s;
    logic [TAG_W-1:0]    l_tag_s, u_tag_s;
    set_t                l_set_s, u_set_s, new_set_s;
    logic [WAY_W-1:0]    u_ptr_s, new_ptr_s;
    logic [NUM_WAYS-1:0] l_valid_s, l_match_s, u_valid_s, u_match_s;
    logic                l_hit_s, u_hit_s, u_wr_s;
    logic [WAY_W-1:0]    l_hit_way_s, u_hit_way_s, u_victim_s, unused_l_victim_s;
    logic                unused_low_bits_s;

    assign unused_low_bits_s = ^{bus.pc[1:0], bus.update_pc[1:0]};

    // Lookup view: pending write overrides the array for its set.
    always_comb begin
        l_idx_s = bus.pc[IDX_W+1:2];
        l_tag_s = bus.pc[ADDR_W-1:IDX_W+2];
        if (pend_valid_r && (pend_idx_r == l_idx_s)) begin
            l_set_s = pend_set_r;
        end else begin
            l_set_s = sets_r[l_idx_s];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            l_valid_s[w] = l_set_s[w].valid;
            l_match_s[w] = (l_set_s[w].tag == l_tag_s);
        end
    end

    btb_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_look_sel (
        .valid(l_valid_s), .match(l_match_s), .ptr({WAY_W{1'b0}}),
        .hit(l_hit_s), .hit_way(l_hit_way_s), .victim_way(unused_l_victim_s)
    );

    // Prediction outputs, zeroed on a miss.
    always_comb begin
        if (l_hit_s) begin
            bus.valid           = 1'b1;
            bus.target_pc       = l_set_s[l_hit_way_s].target;
            bus.predicted_taken = l_set_s[l_hit_way_s].ctr[CTR_W-1];
        end else begin
            bus.valid           = 1'b0;
            bus.target_pc       = '0;
            bus.predicted_taken = 1'b0;
        end
    end

    // Update view of the target set, forwarded from the pending write.
    always_comb begin
        u_idx_s = bus.update_pc[IDX_W+1:2];
        u_tag_s = bus.update_pc[ADDR_W-1:IDX_W+2];
        if (pend_valid_r && (pend_idx_r == u_idx_s)) begin
            u_set_s = pend_set_r;
            u_ptr_s = pend_ptr_r;
        end else begin
            u_set_s = sets_r[u_idx_s];
            u_ptr_s = ptr_r[u_idx_s];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            u_valid_s[w] = u_set_s[w].valid;
            u_match_s[w] = (u_set_s[w].tag == u_tag_s);
        end
    end

    btb_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_upd_sel (
        .valid(u_valid_s), .match(u_match_s), .ptr(u_ptr_s),
        .hit(u_hit_s), .hit_way(u_hit_way_s), .victim_way(u_victim_s)
    );

    // New set contents: counter/target update on hit, allocation on taken miss.
    always_comb begin
        new_set_s = u_set_s;
        new_ptr_s = u_ptr_s;
        u_wr_s    = 1'b0;
        if (u_hit_s) begin
            u_wr_s = 1'b1;
            if (bus.update_taken) begin
                new_set_s[u_hit_way_s].ctr    = CTR_W'(sat_inc(32'(u_set_s[u_hit_way_s].ctr), CTR_W));
                new_set_s[u_hit_way_s].target = bus.update_target;
            end else begin
                new_set_s[u_hit_way_s].ctr    = CTR_W'(sat_dec(32'(u_set_s[u_hit_way_s].ctr)));
            end
        end else if (bus.update_taken) begin
            u_wr_s = 1'b1;
            new_set_s[u_victim_s].valid  = 1'b1;
            new_set_s[u_victim_s].tag    = u_tag_s;
            new_set_s[u_victim_s].target = bus.update_target;
            new_set_s[u_victim_s].ctr    = CTR_WEAK;
            if (u_victim_s == u_ptr_s) begin
                new_ptr_s = (u_ptr_s == WAY_W'(NUM_WAYS - 1)) ? '0 : u_ptr_s + WAY_W'(1);
            end else begin
                new_ptr_s = u_ptr_s;
            end
        end else begin
            u_wr_s = 1'b0;
        end
    end

    // Pending-write register; flush and reset drop any in-flight update.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            pend_valid_r <= 1'b0;
            pend_idx_r   <= '0;
            pend_set_r   <= '0;
            pend_ptr_r   <= '0;
        end else begin
            pend_valid_r <= bus.update & u_wr_s;
            pend_idx_r   <= u_idx_s;
            pend_set_r   <= new_set_s;
            pend_ptr_r   <= new_ptr_s;
        end
    end

    // Array commit of the pending write; flush clears entries and pointers.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                sets_r[s] <= '0;
                ptr_r[s]  <= '0;
            end
        end else if (pend_valid_r) begin
            sets_r[pend_idx_r] <= pend_set_r;
            ptr_r[pend_idx_r]  <= pend_ptr_r;
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed plan plus randomized traffic for btb_assoc, checked against an
// architectural model where every update takes effect at the clock edge.
module tb_btb_assoc;
    localparam int NS = 8;
    localparam int NW = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    bit          m_valid [NS][NW];
    int unsigned m_tag   [NS][NW];
    int unsigned m_tgt   [NS][NW];
    int unsigned m_ctr   [NS][NW];
    int unsigned m_ptr   [NS];

    btb_assoc_if #(.ADDR_W(32)) bus ();

    btb_assoc #(.ADDR_W(32), .NUM_SETS(NS), .NUM_WAYS(NW), .CTR_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_ctr[s][w]   = 0;
            end
        end
    endtask

    task automatic model_find(input int unsigned a, output int hw);
        int unsigned s, t;
        s = (a >> 2) % NS;
        t = a >> 5;
        hw = -1;
        for (int w = NW - 1; w >= 0; w--)
            if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    endtask

    task automatic model_edge();
        int unsigned s, t, a;
        int hw, v;
        if (rst || bus.flush) begin
            model_clear();
        end else if (bus.update) begin
            a = bus.update_pc;
            s = (a >> 2) % NS;
            t = a >> 5;
            model_find(a, hw);
            if (hw >= 0) begin
                if (bus.update_taken) begin
                    m_ctr[s][hw] = (m_ctr[s][hw] == CMAX) ? CMAX : m_ctr[s][hw] + 1;
                    m_tgt[s][hw] = bus.update_target;
                end else begin
                    m_ctr[s][hw] = (m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1;
                end
            end else if (bus.update_taken) begin
                v = -1;
                for (int w = NW - 1; w >= 0; w--)
                    if (!m_valid[s][w]) v = w;
                if (v < 0) v = int'(m_ptr[s]);
                if (v == int'(m_ptr[s])) m_ptr[s] = (m_ptr[s] + 1) % NW;
                m_valid[s][v] = 1'b1;
                m_tag[s][v]   = t;
                m_tgt[s][v]   = bus.update_target;
                m_ctr[s][v]   = 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_upd(input bit en, input logic [31:0] a, input logic [31:0] tgt, input bit tk);
        bus.update        = en;
        bus.update_pc     = a;
        bus.update_target = tgt;
        bus.update_taken  = tk;
    endtask

    task automatic cmp(input string tag, input logic [31:0] a, input bit ev, input logic [31:0] et, input bit ep);
        bus.pc = a;
        #1;
        n_vec++;
        assert (bus.valid === ev) else begin
            n_err++;
            $error("FAIL %s valid pc=%h got %b want %b", tag, a, bus.valid, ev);
        end
        n_vec++;
        assert (bus.target_pc === et) else begin
            n_err++;
            $error("FAIL %s target pc=%h got %h want %h", tag, a, bus.target_pc, et);
        end
        n_vec++;
        assert (bus.predicted_taken === ep) else begin
            n_err++;
            $error("FAIL %s pred pc=%h got %b want %b", tag, a, bus.predicted_taken, ep);
        end
    endtask

    task automatic cmp_model(input string tag, input logic [31:0] a);
        int hw;
        int unsigned s;
        s = (a >> 2) % NS;
        model_find(a, hw);
        if (hw >= 0) cmp(tag, a, 1'b1, m_tgt[s][hw], m_ctr[s][hw] >= 2);
        else         cmp(tag, a, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int unsigned a;
        bus.pc = 32'h0;
        bus.flush = 1'b0;
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        model_clear();

        // 1: reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cmp("reset", 32'h1000, 1'b0, 32'h0, 1'b0);

        // 2: first allocation visible through the bypass
        set_upd(1'b1, 32'h1000, 32'h2000, 1'b1);
        tick();
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("alloc", 32'h1000, 1'b1, 32'h2000, 1'b1);

        // 3: counter walk
        set_upd(1'b1, 32'h1000, 32'h5555, 1'b0);
        tick();
        cmp("dec1", 32'h1000, 1'b1, 32'h2000, 1'b0);
        tick();
        tick();
        cmp("dec_floor", 32'h1000, 1'b1, 32'h2000, 1'b0);
        set_upd(1'b1, 32'h1000, 32'h2000, 1'b1);
        tick();
        cmp("inc1", 32'h1000, 1'b1, 32'h2000, 1'b0);
        tick();
        cmp("inc2", 32'h1000, 1'b1, 32'h2000, 1'b1);
        tick();
        tick();
        tick();
        set_upd(1'b1, 32'h1000, 32'h0, 1'b0);
        tick();
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("sat_then_dec", 32'h1000, 1'b1, 32'h2000, 1'b1);

        // 4: conflicts in set 0
        set_upd(1'b1, 32'h1000, 32'hA0, 1'b1);
        tick();
        set_upd(1'b1, 32'h1020, 32'hB0, 1'b1);
        tick();
        set_upd(1'b1, 32'h1040, 32'hC0, 1'b1);
        tick();
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("evict_way0", 32'h1000, 1'b0, 32'h0, 1'b0);
        cmp("keep_way1", 32'h1020, 1'b1, 32'hB0, 1'b1);
        cmp("new_way0", 32'h1040, 1'b1, 32'hC0, 1'b1);
        set_upd(1'b1, 32'h1060, 32'hD0, 1'b1);
        tick();
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("rr_evict_way1", 32'h1020, 1'b0, 32'h0, 1'b0);
        cmp("rr_new_way1", 32'h1060, 1'b1, 32'hD0, 1'b1);
        cmp("rr_keep_way0", 32'h1040, 1'b1, 32'hC0, 1'b1);

        // 5: back-to-back updates to one set
        set_upd(1'b1, 32'h1000, 32'h2000, 1'b1);
        tick();
        set_upd(1'b1, 32'h1000, 32'h9999, 1'b0);
        tick();
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("b2b", 32'h1000, 1'b1, 32'h2000, 1'b0);
        tick();
        cmp("b2b_commit", 32'h1000, 1'b1, 32'h2000, 1'b0);

        // 6: flush beats a simultaneous update
        bus.flush = 1'b1;
        set_upd(1'b1, 32'h3000, 32'h3300, 1'b1);
        tick();
        bus.flush = 1'b0;
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("flush_1000", 32'h1000, 1'b0, 32'h0, 1'b0);
        cmp("flush_1060", 32'h1060, 1'b0, 32'h0, 1'b0);
        cmp("flush_3000", 32'h3000, 1'b0, 32'h0, 1'b0);

        // 7: not-taken miss does not allocate
        set_upd(1'b1, 32'h4000, 32'h4400, 1'b0);
        tick();
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("nt_noalloc", 32'h4000, 1'b0, 32'h0, 1'b0);

        // Randomized traffic over a few sets and tags to force reuse and eviction
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(32'h80, 32'h83) << 5) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            set_upd($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 59) == 0);
            a = ($urandom_range(32'h80, 32'h83) << 5) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            cmp_model("rand", a);
            tick();
        end
        bus.flush = 1'b0;
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);

        // Update during reset is ignored
        rst = 1'b1;
        set_upd(1'b1, 32'h5000, 32'h5500, 1'b1);
        tick();
        rst = 1'b0;
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        cmp("rst_drop", 32'h5000, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer. It is the successor to the fixed 8-set BTB in the fetch/control path.
- Each entry keeps a per-entry saturating direction counter, so taken/not-taken is predicted per branch instead of implied by a hit.
- Victims are chosen per set: invalid way first, then round-robin.
- Adds a flush input and forwarding of the in-flight write.
- Sits beside the PC register: combinational lookup for fetch, resolved-branch updates from execute.

Parameters:
- ADDR_W, 32, PC width.
- NUM_SETS, 8, number of sets; power of 2, at least 2. IDX_W = clog2(NUM_SETS).
- NUM_WAYS, 2, associativity; power of 2, at least 1. WAY_W = max(1, clog2(NUM_WAYS)).
- CTR_W, 2, direction counter width, at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- pc  in  ADDR_W  fetch PC to look up
- target_pc  out  ADDR_W  predicted target; 0 on miss
- valid  out  1  lookup hit
- predicted_taken  out  1  hit AND counter MSB
- update  in  1  resolved-branch update strobe
- update_pc  in  ADDR_W  PC of the resolved branch
- update_target  in  ADDR_W  resolved target
- update_taken  in  1  actual branch outcome
- flush  in  1  invalidate all entries

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - the same split applies to update_pc.
- Entry fields: valid bit, tag, target, CTR_W counter. Each set also holds a WAY_W round-robin pointer.
- Reset, at the clk edge with rst=1:
  - all valid bits, counters and pointers go to 0;
  - the pending-write register is cleared.
  - Result: valid=0, predicted_taken=0, target_pc=0 from the cycle after reset until the first update.
- Lookup is purely combinational from the array merged with the pending write (zero latency).
  - Several valid ways matching is an illegal state; if it occurs, the lowest way index wins.
- Update pipeline, update=1 in cycle t:
  - In cycle t, compute the new set contents from the array merged with the pending write (forwarding).
  - At the end of t, register the result into the pending-write register.
  - At the end of t+1, commit it to the array.
  - A lookup in cycle t+1 already returns the new entry through the bypass.
  - Back-to-back updates to the same set must compose correctly.
- Update on hit (valid way with matching tag):
  - update_taken=1: counter saturating-increments (max 2^CTR_W-1) and target <= update_target.
  - update_taken=0: counter saturating-decrements (min 0); target unchanged.
  - Round-robin pointer unchanged.
- Update on miss:
  - update_taken=1: allocate the lowest-index invalid way, or if none is invalid, the way at the set pointer. Write valid=1, the tag, the target, and counter = 1<<(CTR_W-1) (weakly taken). Advance the pointer by 1 mod NUM_WAYS only when the pointer's way was the victim.
  - update_taken=0: no write, no pointer change.
- Flush:
  - flush=1 clears every valid bit and the pending write at the next edge.
  - Counters and pointers are reset to 0.
  - flush and update in the same cycle: flush wins and the update is dropped.
- rst has priority over flush and update.
- update while rst=1 is ignored.

Decomposition:
- Package btb_pkg:
  - clog2 function;
  - entry typedef (valid, tag, target, ctr) and set typedef;
  - CTR_WEAK_TAKEN constant;
  - saturating inc/dec functions.
- Sub-module btb_victim_sel: combinational hit priority encoder plus victim choice (first invalid way, else pointer). Used by both the lookup and update paths.

Test Plan (NUM_SETS=8, NUM_WAYS=2, CTR_W=2):
1. rst for 2 cycles, then pc=0x0000_1000 -> valid=0, predicted_taken=0, target_pc=0x0000_0000.
2. Cycle t: update pc 0x1000, taken, target 0x2000. Cycle t+1: pc=0x1000 -> valid=1, target_pc=0x2000, predicted_taken=1 (ctr=2).
3. Counter walk on 0x1000:
   - two not-taken updates -> ctr 1 then 0; valid=1, predicted_taken=0;
   - then four taken updates -> ctr 1,2,3,3 (saturates); predicted_taken=1.
4. Conflict in set 0: taken updates to 0x1000, 0x1020, 0x1040 (targets 0xA0, 0xB0, 0xC0) -> 0x1040 evicts way0. Lookups: 0x1000 miss; 0x1020 hit 0xB0; 0x1040 hit 0xC0; set pointer=1.
5. Back-to-back updates to 0x1000 in consecutive cycles (taken/target 0x2000, then not-taken) -> ctr=1 after commit (forwarding); next-cycle lookup gives valid=1, predicted_taken=0, target_pc=0x2000.
6. flush=1 together with update (0x3000, taken) -> next cycle all earlier PCs and 0x3000 miss (valid=0).
7. Not-taken update to an absent PC 0x4000 -> no allocation; lookup of 0x4000 misses.
